// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle for the framebuffer arbiter: display fetch port, host port and
// the single-port RAM port. The arbiter uses the slave view, its
// environment (display fetch, host, RAM) uses the master view.
interface vga_fb_arbiter_if #(
   parameter int AW = 11,
   parameter int DW = 8
);
   logic          activevideo_i;
   logic          disp_req_i;
   logic [AW-1:0] disp_addr_i;
   logic          disp_rvalid_o;
   logic [DW-1:0] disp_rdata_o;
   logic          host_valid_i;
   logic          host_ready_o;
   logic          host_we_i;
   logic [AW-1:0] host_addr_i;
   logic [DW-1:0] host_wdata_i;
   logic          host_rvalid_o;
   logic [DW-1:0] host_rdata_o;
   logic          host_starve_o;
   logic          mem_en_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;

   modport slave (
      input  activevideo_i, disp_req_i, disp_addr_i,
      input  host_valid_i, host_we_i, host_addr_i, host_wdata_i,
      input  mem_rdata_i,
      output disp_rvalid_o, disp_rdata_o,
      output host_ready_o, host_rvalid_o, host_rdata_o, host_starve_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output activevideo_i, disp_req_i, disp_addr_i,
      output host_valid_i, host_we_i, host_addr_i, host_wdata_i,
      output mem_rdata_i,
      input  disp_rvalid_o, disp_rdata_o,
      input  host_ready_o, host_rvalid_o, host_rdata_o, host_starve_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display reads always win, host requests wait in a
// one-entry holding register and go out in free cycles. A tag pipeline
// RD_LAT deep routes returning read data to its owner; a saturating wait
// counter flags host starvation seen during blanking.
module vga_fb_arbiter #(
   parameter int AW         = 11,
   parameter int DW         = 8,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   vga_fb_arbiter_if.slave  bus
);
   localparam logic [7:0] SMAX = 8'(STARVE_MAX);

   typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_e;

   hold_e            hold_q, hold_d;
   logic             h_we_q, h_we_d;
   logic [AW-1:0]    h_addr_q, h_addr_d;
   logic [DW-1:0]    h_wdata_q, h_wdata_d;
   logic [AW-1:0]    addr_q;
   logic [DW-1:0]    wdata_q;
   logic [RD_LAT-1:0] tvld_q, town_q, tvld_n, town_n;
   logic [DW-1:0]    drd_q, hrd_q;
   logic [7:0]       wcnt_q, wcnt_d;
   logic             starve_q, starve_d;
   logic             issue_disp, issue_host, ready, accept, tag_push;
   logic             disp_rv, host_rv;

   // Arbitration, holding-register next state and host handshake
   always_comb begin
      issue_disp = !rst_i && bus.disp_req_i;
      issue_host = !rst_i && !bus.disp_req_i && (hold_q == HOLD_FULL);
      ready      = !rst_i && ((hold_q == HOLD_EMPTY) || issue_host);
      accept     = ready && bus.host_valid_i;
      hold_d     = hold_q;
      h_we_d     = h_we_q;
      h_addr_d   = h_addr_q;
      h_wdata_d  = h_wdata_q;
      if (issue_host) hold_d = HOLD_EMPTY;
      // a new request may refill the register in the cycle it drains
      if (accept) begin
         hold_d    = HOLD_FULL;
         h_we_d    = bus.host_we_i;
         h_addr_d  = bus.host_addr_i;
         h_wdata_d = bus.host_wdata_i;
      end
      bus.host_ready_o = ready;
   end

   // RAM port: the winner drives address/data, idle cycles keep the last value
   always_comb begin
      bus.mem_en_o    = issue_disp || issue_host;
      bus.mem_we_o    = issue_host && h_we_q;
      bus.mem_addr_o  = addr_q;
      bus.mem_wdata_o = wdata_q;
      if (issue_disp) begin
         bus.mem_addr_o = bus.disp_addr_i;
      end else if (issue_host) begin
         bus.mem_addr_o  = h_addr_q;
         bus.mem_wdata_o = h_wdata_q;
      end
      if (rst_i) begin
         bus.mem_addr_o  = '0;
         bus.mem_wdata_o = '0;
      end
      tag_push = issue_disp || (issue_host && !h_we_q);
   end

   // Tag pipeline input: stage 0 takes the tag of the read issued this cycle
   generate
      if (RD_LAT == 1) begin : g_tag1
         assign tvld_n = tag_push;
         assign town_n = issue_host;
      end else begin : g_tagn
         assign tvld_n = {tvld_q[RD_LAT-2:0], tag_push};
         assign town_n = {town_q[RD_LAT-2:0], issue_host};
      end
   endgenerate

   // Read return: the tag at depth RD_LAT picks the requester for mem_rdata_i
   always_comb begin
      disp_rv = !rst_i && tvld_q[RD_LAT-1] && !town_q[RD_LAT-1];
      host_rv = !rst_i && tvld_q[RD_LAT-1] &&  town_q[RD_LAT-1];
      bus.disp_rvalid_o = disp_rv;
      bus.host_rvalid_o = host_rv;
      bus.disp_rdata_o  = rst_i ? '0 : (disp_rv ? bus.mem_rdata_i : drd_q);
      bus.host_rdata_o  = rst_i ? '0 : (host_rv ? bus.mem_rdata_i : hrd_q);
      bus.host_starve_o = !rst_i && starve_q;
   end

   // Starvation: count blanking cycles a pending host request is passed over
   always_comb begin
      wcnt_d = wcnt_q;
      if (issue_host)
         wcnt_d = '0;
      else if ((hold_q == HOLD_FULL) && !bus.activevideo_i && (wcnt_q < SMAX))
         wcnt_d = wcnt_q + 8'd1;
      starve_d = starve_q || (wcnt_d >= SMAX);
   end

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_q    <= HOLD_EMPTY;
         h_we_q    <= 1'b0;
         h_addr_q  <= '0;
         h_wdata_q <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         tvld_q    <= '0;
         town_q    <= '0;
         drd_q     <= '0;
         hrd_q     <= '0;
         wcnt_q    <= '0;
         starve_q  <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         h_we_q    <= h_we_d;
         h_addr_q  <= h_addr_d;
         h_wdata_q <= h_wdata_d;
         if (bus.mem_en_o) addr_q  <= bus.mem_addr_o;
         if (issue_host)   wdata_q <= h_wdata_q;
         tvld_q    <= tvld_n;
         town_q    <= town_n;
         if (disp_rv) drd_q <= bus.mem_rdata_i;
         if (host_rv) hrd_q <= bus.mem_rdata_i;
         wcnt_q    <= wcnt_d;
         starve_q  <= starve_d;
      end
   end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: instance A (RD_LAT=1, STARVE_MAX=4) and
// instance B (RD_LAT=3). Read data is tracked by a scoreboard fed at
// request time from a reference memory; issue behaviour is table driven.
module tb_vga_fb_arbiter;
   localparam int AW = 11;
   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   vga_fb_arbiter_if #(.AW(AW), .DW(DW)) ia ();
   vga_fb_arbiter_if #(.AW(AW), .DW(DW)) ib ();

   vga_fb_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE_MAX(4)) dut_a (
      .clk_i(clk), .rst_i(rst_a), .bus(ia));
   vga_fb_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .STARVE_MAX(255)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .bus(ib));

   function automatic logic [7:0] init_f(int i);
      return 8'((i ^ (i >> 3) ^ 'h5A) & 'hFF);
   endfunction

   // RAM models: A is a writable 1-cycle RAM, B a read-only 3-cycle RAM
   logic [7:0] ram_a [2048];
   logic [7:0] ref_a [2048];
   logic [7:0] rd_a = 8'h00;
   logic [7:0] pb [3];

   always @(posedge clk) begin
      if (ia.mem_en_o && ia.mem_we_o) ram_a[ia.mem_addr_o] = ia.mem_wdata_o;
      if (ia.mem_en_o && !ia.mem_we_o) rd_a <= ram_a[ia.mem_addr_o];
   end
   assign ia.mem_rdata_i = rd_a;

   always @(posedge clk) begin
      pb[0] <= (ib.mem_en_o && !ib.mem_we_o) ? init_f(int'(ib.mem_addr_o)) : 8'h00;
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign ib.mem_rdata_i = pb[2];

   typedef struct {
      logic [7:0] data;
      int         due;
      int         acc;
   } exp_t;

   exp_t dqa[$], hqa[$], dqb[$], hqb[$];

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexp(string name);
      checks++;
      errors++;
      $display("FAIL %s: rvalid with no outstanding read (cycle %0d)", name, cyc);
   endtask

   task automatic ret(string name, exp_t e, logic [7:0] d, logic host, int rl);
      chk({name, "_data"}, int'(d), int'(e.data));
      if (host) chk({name, "_lat_ok"}, int'(cyc >= e.acc + rl + 1), 1);
      else      chk({name, "_lat"}, cyc, e.due);
   endtask

   // Scoreboard A: compare returns first, then record this cycle's requests
   always @(negedge clk) begin
      exp_t e;
      if (ia.disp_rvalid_o) begin
         if (dqa.size() == 0) unexp("dispA");
         else begin e = dqa.pop_front(); ret("dispA", e, ia.disp_rdata_o, 1'b0, 1); end
      end
      if (ia.host_rvalid_o) begin
         if (hqa.size() == 0) unexp("hostA");
         else begin e = hqa.pop_front(); ret("hostA", e, ia.host_rdata_o, 1'b1, 1); end
      end
      if (rst_a) begin
         dqa.delete();
         hqa.delete();
      end else begin
         if (ia.disp_req_i) dqa.push_back('{ref_a[ia.disp_addr_i], cyc + 1, cyc});
         if (ia.host_valid_i && ia.host_ready_o) begin
            if (ia.host_we_i) ref_a[ia.host_addr_i] = ia.host_wdata_i;
            else hqa.push_back('{ref_a[ia.host_addr_i], 0, cyc});
         end
      end
   end

   // Scoreboard B: reset drops everything in flight
   always @(negedge clk) begin
      exp_t e;
      if (ib.disp_rvalid_o) begin
         if (dqb.size() == 0) unexp("dispB");
         else begin e = dqb.pop_front(); ret("dispB", e, ib.disp_rdata_o, 1'b0, 3); end
      end
      if (ib.host_rvalid_o) begin
         if (hqb.size() == 0) unexp("hostB");
         else begin e = hqb.pop_front(); ret("hostB", e, ib.host_rdata_o, 1'b1, 3); end
      end
      if (rst_b) begin
         dqb.delete();
         hqb.delete();
      end else begin
         if (ib.disp_req_i) dqb.push_back('{init_f(int'(ib.disp_addr_i)), cyc + 3, cyc});
         if (ib.host_valid_i && ib.host_ready_o && !ib.host_we_i)
            hqb.push_back('{init_f(int'(ib.host_addr_i)), 0, cyc});
      end
   end

   task automatic drv_a(logic d, logic [10:0] da, logic hv, logic we,
                        logic [10:0] ha, logic [7:0] wd, logic av);
      ia.disp_req_i    = d;
      ia.disp_addr_i   = da;
      ia.host_valid_i  = hv;
      ia.host_we_i     = we;
      ia.host_addr_i   = ha;
      ia.host_wdata_i  = wd;
      ia.activevideo_i = av;
   endtask

   task automatic drv_b(logic d, logic [10:0] da, logic hv, logic [10:0] ha);
      ib.disp_req_i    = d;
      ib.disp_addr_i   = da;
      ib.host_valid_i  = hv;
      ib.host_we_i     = 1'b0;
      ib.host_addr_i   = ha;
      ib.host_wdata_i  = 8'h00;
      ib.activevideo_i = 1'b1;
   endtask

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        d;
      logic [10:0] da;
      logic        hv;
      logic        we;
      logic [10:0] ha;
      logic [7:0]  wd;
      logic        en_x;
      logic        we_x;
      logic [10:0] addr_x;
      logic [7:0]  wd_x;
      logic        rdy_x;
   } vec_t;

   vec_t tbl [13];

   initial begin
      for (int i = 0; i < 2048; i++) begin
         ram_a[i] = init_f(i);
         ref_a[i] = init_f(i);
      end
      //            d  da      hv we ha      wd      en we addr    wd     rdy
      tbl[0]  = '{1, 11'h010, 0, 0, 11'h000, 8'h00, 1, 0, 11'h010, 8'h00, 1};
      tbl[1]  = '{1, 11'h011, 0, 0, 11'h000, 8'h00, 1, 0, 11'h011, 8'h00, 1};
      tbl[2]  = '{1, 11'h012, 0, 0, 11'h000, 8'h00, 1, 0, 11'h012, 8'h00, 1};
      tbl[3]  = '{1, 11'h013, 0, 0, 11'h000, 8'h00, 1, 0, 11'h013, 8'h00, 1};
      tbl[4]  = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 0, 11'h013, 8'h00, 1};
      tbl[5]  = '{0, 11'h000, 1, 1, 11'h2A5, 8'h5C, 0, 0, 11'h013, 8'h00, 1};
      tbl[6]  = '{0, 11'h000, 1, 0, 11'h2A5, 8'h77, 1, 1, 11'h2A5, 8'h5C, 1};
      tbl[7]  = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 1, 0, 11'h2A5, 8'h77, 1};
      tbl[8]  = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 0, 11'h2A5, 8'h77, 1};
      tbl[9]  = '{1, 11'h020, 1, 0, 11'h2A5, 8'h00, 1, 0, 11'h020, 8'h77, 1};
      tbl[10] = '{1, 11'h021, 0, 0, 11'h000, 8'h00, 1, 0, 11'h021, 8'h77, 0};
      tbl[11] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 1, 0, 11'h2A5, 8'h00, 1};
      tbl[12] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 0, 11'h2A5, 8'h00, 1};

      // Reset held 3 cycles with requests present
      rst_a = 1'b1;
      rst_b = 1'b1;
      drv_a(1'b1, 11'h3FF, 1'b1, 1'b1, 11'h007, 8'hAA, 1'b1);
      drv_b(1'b0, 11'h000, 1'b0, 11'h000);
      repeat (3) begin
         @(negedge clk);
         chk("rst_mem_en", int'(ia.mem_en_o), 0);
         chk("rst_ready", int'(ia.host_ready_o), 0);
         chk("rst_rvalid", int'(ia.disp_rvalid_o | ia.host_rvalid_o), 0);
         next_cyc();
      end
      rst_a = 1'b0;
      rst_b = 1'b0;
      drv_a(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0);
      @(negedge clk);
      chk("post_rst_ready", int'(ia.host_ready_o), 1);
      chk("post_rst_mem_en", int'(ia.mem_en_o), 0);
      chk("post_rst_starve", int'(ia.host_starve_o), 0);
      next_cyc();

      // Issue selection table (display burst, host write/read, contention)
      for (int i = 0; i < 13; i++) begin
         drv_a(tbl[i].d, tbl[i].da, tbl[i].hv, tbl[i].we, tbl[i].ha, tbl[i].wd, 1'b0);
         @(negedge clk);
         chk($sformatf("row%0d_en", i),    int'(ia.mem_en_o),    int'(tbl[i].en_x));
         chk($sformatf("row%0d_we", i),    int'(ia.mem_we_o),    int'(tbl[i].we_x));
         chk($sformatf("row%0d_addr", i),  int'(ia.mem_addr_o),  int'(tbl[i].addr_x));
         chk($sformatf("row%0d_wdata", i), int'(ia.mem_wdata_o), int'(tbl[i].wd_x));
         chk($sformatf("row%0d_ready", i), int'(ia.host_ready_o), int'(tbl[i].rdy_x));
         next_cyc();
      end
      drv_a(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
      next_cyc();
      @(negedge clk);
      chk("disp_rdata_hold", int'(ia.disp_rdata_o), int'(init_f('h021)));
      chk("host_rdata_hold", int'(ia.host_rdata_o), 'h5C);
      next_cyc();

      // Contention: pending host read vs 10 display cycles in active video
      drv_a(1'b0, 11'h000, 1'b1, 1'b0, 11'h123, 8'h00, 1'b1);
      @(negedge clk);
      chk("cont_accept_ready", int'(ia.host_ready_o), 1);
      next_cyc();
      for (int i = 1; i <= 10; i++) begin
         drv_a(1'b1, 11'(11'h100 + i), 1'b1, 1'b1, 11'h124, 8'h99, 1'b1);
         @(negedge clk);
         chk("cont_disp_addr", int'(ia.mem_addr_o), 'h100 + i);
         chk("cont_disp_we", int'(ia.mem_we_o), 0);
         chk("cont_ready_low", int'(ia.host_ready_o), 0);
         next_cyc();
      end
      drv_a(1'b0, 11'h000, 1'b1, 1'b1, 11'h124, 8'h99, 1'b1);
      @(negedge clk);
      chk("cont_host_en", int'(ia.mem_en_o), 1);
      chk("cont_host_addr", int'(ia.mem_addr_o), 'h123);
      chk("cont_host_ready", int'(ia.host_ready_o), 1);
      next_cyc();
      drv_a(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
      @(negedge clk);
      chk("cont_wr_we", int'(ia.mem_we_o), 1);
      chk("cont_wr_addr", int'(ia.mem_addr_o), 'h124);
      chk("cont_wr_data", int'(ia.mem_wdata_o), 'h99);
      next_cyc();
      @(negedge clk);
      chk("cont_no_starve", int'(ia.host_starve_o), 0);
      next_cyc();

      // Starvation in blanking: host read passed over by continuous display
      drv_a(1'b0, 11'h000, 1'b1, 1'b0, 11'h1F0, 8'h00, 1'b0);
      @(negedge clk);
      chk("starve_accept", int'(ia.host_ready_o), 1);
      next_cyc();
      for (int i = 1; i <= 6; i++) begin
         drv_a(1'b1, 11'(11'h200 + i), 1'b0, 1'b0, 11'h000, 8'h00, 1'b0);
         @(negedge clk);
         chk($sformatf("starve_wait%0d", i), int'(ia.host_starve_o), int'(i >= 5));
         next_cyc();
      end
      drv_a(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0);
      @(negedge clk);
      chk("starve_drain_addr", int'(ia.mem_addr_o), 'h1F0);
      chk("starve_drain_en", int'(ia.mem_en_o), 1);
      next_cyc();
      repeat (3) begin
         @(negedge clk);
         chk("starve_sticky", int'(ia.host_starve_o), 1);
         next_cyc();
      end

      // RD_LAT=3: interleaved reads, then reset with two reads in flight
      drv_b(1'b1, 11'h040, 1'b1, 11'h055);  next_cyc();
      drv_b(1'b0, 11'h000, 1'b0, 11'h000);
      @(negedge clk);
      chk("b_host_issue_addr", int'(ib.mem_addr_o), 'h055);
      next_cyc();
      drv_b(1'b1, 11'h041, 1'b0, 11'h000);  next_cyc();
      drv_b(1'b0, 11'h000, 1'b0, 11'h000);  next_cyc();
      next_cyc();
      drv_b(1'b0, 11'h000, 1'b1, 11'h066);  next_cyc();
      drv_b(1'b0, 11'h000, 1'b0, 11'h000);  next_cyc();
      drv_b(1'b1, 11'h043, 1'b0, 11'h000);  next_cyc();
      drv_b(1'b0, 11'h000, 1'b0, 11'h000);
      rst_b = 1'b1;
      @(negedge clk);
      chk("b_rst_ready", int'(ib.host_ready_o), 0);
      next_cyc();
      rst_b = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("b_post_rst_disp_rv", int'(ib.disp_rvalid_o), 0);
         chk("b_post_rst_host_rv", int'(ib.host_rvalid_o), 0);
         next_cyc();
      end
      @(negedge clk);
      chk("b_post_rst_ready", int'(ib.host_ready_o), 1);
      chk("b_no_starve", int'(ib.host_starve_o), 0);

      repeat (4) next_cyc();
      chk("dispA_drain", dqa.size(), 0);
      chk("hostA_drain", hqa.size(), 0);
      chk("dispB_drain", dqb.size(), 0);
      chk("hostB_drain", hqb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
